// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - Fibonacci/Galois LFSR with seed load, lock-up recovery and period measurement
module lfsr_gen #(
  parameter int               WIDTH  = 4,
  parameter logic [WIDTH-1:0] TAPS   = 4'b1100,
  parameter bit               GALOIS = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             en,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] state,
  output logic             serial_out,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             lockup
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] ref_state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] step_next;
  logic [WIDTH-1:0] cnt_inc;
  logic             state_zero;

  always_comb begin
    step_next = '0;
    if (GALOIS)
      step_next = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? TAPS : '0);
    else
      step_next = {state[WIDTH-2:0], ^(state & TAPS)};
  end

  // cnt_inc doubles as the saturated period value on a match.
  assign cnt_inc    = (cnt == '1) ? cnt : cnt + ONE;
  assign state_zero = (state == '0);
  assign serial_out = state[WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= '0;
      ref_state    <= '0;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      lockup       <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (!sel) begin
        state     <= seed;
        ref_state <= seed;
        cnt       <= '0;
        lockup    <= 1'b0;
      end else if (en) begin
        if (state_zero) begin
          // Escape the all-zero trap and restart measurement from the new state.
          state     <= ONE;
          ref_state <= ONE;
          cnt       <= '0;
          lockup    <= 1'b1;
        end else begin
          state <= step_next;
          if (step_next == ref_state) begin
            period       <= cnt_inc;
            period_valid <= 1'b1;
            cnt          <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
      end
    end
  end

endmodule
